// File: rtl/player_lane_controller.sv
// Player lane, fire cooldown, lives and game-over tracking for the playfield.
// Define PLAYER_WRAP_EN to make lane movement wrap around instead of saturating.
module player_lane_controller #(
  parameter int NUM_LANES  = 8,
  parameter int LANE_W     = $clog2(NUM_LANES),
  parameter int START_LANE = 0,
  parameter int LIVES      = 3,
  parameter int COOLDOWN   = 4,
  parameter int INVULN     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button_up,
  input  logic                 button_down,
  input  logic                 button_fire,
  input  logic                 projectile_hit,
  output logic [NUM_LANES-1:0] lane_onehot,
  output logic [LANE_W-1:0]    lane_idx,
  output logic                 fire_pulse,
  output logic [LANE_W-1:0]    fire_lane,
  output logic [3:0]           lives,
  output logic                 invulnerable,
  output logic                 game_over
);

  typedef enum logic [1:0] {ST_PLAY, ST_HIT, ST_OVER} state_t;

  localparam int CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam int INV_W = (INVULN < 1) ? 1 : $clog2(INVULN + 1);
  localparam logic [LANE_W-1:0] START_IDX = LANE_W'(START_LANE);
  localparam logic [LANE_W-1:0] LAST_IDX  = LANE_W'(NUM_LANES - 1);
  localparam logic [3:0]        LIVES_INIT = 4'(LIVES);

  state_t            state, state_n;
  logic [2:0]        btn_s1, btn_s2, btn_prev, btn_edge;
  logic              hit_prev, hit_edge;
  logic              up_edge, down_edge, fire_edge;
  logic [CD_W-1:0]   cooldown, cooldown_n;
  logic [INV_W-1:0]  inv_cnt, inv_cnt_n;
  logic [LANE_W-1:0] lane_move, lane_n, fire_lane_n;
  logic [3:0]        lives_n;
  logic              fire_pulse_n;

  // Buttons are asynchronous: two-flop synchroniser plus a history flop per button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
      hit_prev <= 1'b0;
    end else begin
      btn_s1   <= {button_fire, button_down, button_up};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      hit_prev <= projectile_hit;
    end
  end

  assign btn_edge  = btn_s2 & ~btn_prev;
  assign up_edge   = btn_edge[0];
  assign down_edge = btn_edge[1];
  assign fire_edge = btn_edge[2];
  assign hit_edge  = projectile_hit & ~hit_prev;

  always_comb begin
    lane_move = lane_idx;
    if (up_edge && !down_edge) begin
      if (lane_idx == LAST_IDX) begin
`ifdef PLAYER_WRAP_EN
        lane_move = '0;
`else
        lane_move = LAST_IDX;
`endif
      end else begin
        lane_move = lane_idx + LANE_W'(1);
      end
    end else if (down_edge && !up_edge) begin
      if (lane_idx == '0) begin
`ifdef PLAYER_WRAP_EN
        lane_move = LAST_IDX;
`else
        lane_move = '0;
`endif
      end else begin
        lane_move = lane_idx - LANE_W'(1);
      end
    end
  end

  // The shot samples the lane before any same-cycle move; a hit is resolved after the shot.
  always_comb begin
    state_n      = state;
    lane_n       = lane_idx;
    fire_pulse_n = 1'b0;
    fire_lane_n  = fire_lane;
    lives_n      = lives;
    inv_cnt_n    = inv_cnt;
    cooldown_n   = (cooldown != '0) ? cooldown - CD_W'(1) : cooldown;

    case (state)
      ST_PLAY, ST_HIT: begin
        lane_n = lane_move;
        if (fire_edge && cooldown == '0) begin
          fire_pulse_n = 1'b1;
          fire_lane_n  = lane_idx;
          cooldown_n   = CD_W'(COOLDOWN);
        end
        if (state == ST_PLAY) begin
          if (hit_edge) begin
            if (lives > 4'd1) begin
              lives_n   = lives - 4'd1;
              inv_cnt_n = INV_W'(INVULN);
              state_n   = ST_HIT;
            end else begin
              lives_n = 4'd0;
              state_n = ST_OVER;
            end
          end
        end else begin
          if (inv_cnt <= INV_W'(1)) begin
            inv_cnt_n = '0;
            state_n   = ST_PLAY;
          end else begin
            inv_cnt_n = inv_cnt - INV_W'(1);
          end
        end
      end
      ST_OVER: begin
        if (fire_edge) begin
          lives_n    = LIVES_INIT;
          lane_n     = START_IDX;
          cooldown_n = CD_W'(COOLDOWN);
          state_n    = ST_PLAY;
        end
      end
      default: state_n = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_PLAY;
      lane_idx    <= START_IDX;
      lane_onehot <= NUM_LANES'(1) << START_IDX;
      fire_pulse  <= 1'b0;
      fire_lane   <= START_IDX;
      lives       <= LIVES_INIT;
      cooldown    <= '0;
      inv_cnt     <= '0;
    end else begin
      state       <= state_n;
      lane_idx    <= lane_n;
      lane_onehot <= NUM_LANES'(1) << lane_n;
      fire_pulse  <= fire_pulse_n;
      fire_lane   <= fire_lane_n;
      lives       <= lives_n;
      cooldown    <= cooldown_n;
      inv_cnt     <= inv_cnt_n;
    end
  end

  assign invulnerable = (state == ST_HIT);
  assign game_over    = (state == ST_OVER);

endmodule

// File: tb/tb_player_lane_controller.sv
// Bench for player_lane_controller: vector table, hand sequences and random stimulus
// against a behavioural model (honours PLAYER_WRAP_EN).
module tb_player_lane_controller;

  localparam int N      = 8;
  localparam int LW     = 3;
  localparam int START  = 0;
  localparam int NLIVES = 3;
  localparam int CD     = 4;
  localparam int INV    = 8;

`ifdef PLAYER_WRAP_EN
  localparam int L_DOWN10 = 2;
  localparam int L_DSAT   = 1;
`else
  localparam int L_DOWN10 = 0;
  localparam int L_DSAT   = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          button_up, button_down, button_fire, projectile_hit;
  logic [N-1:0]  lane_onehot;
  logic [LW-1:0] lane_idx, fire_lane;
  logic          fire_pulse;
  logic [3:0]    lives;
  logic          invulnerable, game_over;

  always #5 clk = ~clk;

  player_lane_controller dut (
    .clk           (clk),
    .rst           (rst),
    .button_up     (button_up),
    .button_down   (button_down),
    .button_fire   (button_fire),
    .projectile_hit(projectile_hit),
    .lane_onehot   (lane_onehot),
    .lane_idx      (lane_idx),
    .fire_pulse    (fire_pulse),
    .fire_lane     (fire_lane),
    .lives         (lives),
    .invulnerable  (invulnerable),
    .game_over     (game_over)
  );

  int total = 0;
  int bad = 0;
  int pulse_count = 0;

  // Reference model: game mode 0=play 1=hit 2=over, plain integer counters,
  // button history as the last three sampled levels.
  int m_lane, m_lives, m_mode, m_cd, m_inv, m_fire_lane;
  bit m_pulse;
  bit [2:0] hu, hd, hf;
  bit m_hit_prev;

  function automatic void model_reset();
    m_lane = START; m_lives = NLIVES; m_mode = 0; m_cd = 0; m_inv = 0;
    m_fire_lane = START; m_pulse = 0;
    hu = '0; hd = '0; hf = '0; m_hit_prev = 0;
  endfunction

  function automatic int moved(int l, int dir);
    int r;
    r = l + dir;
`ifdef PLAYER_WRAP_EN
    if (r > N - 1) r = 0;
    if (r < 0) r = N - 1;
`else
    if (r > N - 1) r = N - 1;
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic void model_update();
    bit eu, ed, ef, eh, fire_ok;
    if (rst) begin
      model_reset();
    end else begin
      eu = hu[1] & ~hu[2];
      ed = hd[1] & ~hd[2];
      ef = hf[1] & ~hf[2];
      eh = projectile_hit & ~m_hit_prev;
      hu = {hu[1:0], button_up};
      hd = {hd[1:0], button_down};
      hf = {hf[1:0], button_fire};
      m_hit_prev = projectile_hit;
      m_pulse = 0;
      if (m_mode == 2) begin
        if (m_cd > 0) m_cd--;
        if (ef) begin
          m_lives = NLIVES; m_lane = START; m_cd = CD; m_mode = 0;
        end
      end else begin
        fire_ok = ef && (m_cd == 0);
        if (m_cd > 0) m_cd--;
        if (fire_ok) begin
          m_pulse = 1; m_fire_lane = m_lane; m_cd = CD;
        end
        if (eu && !ed) m_lane = moved(m_lane, 1);
        if (ed && !eu) m_lane = moved(m_lane, -1);
        if (m_mode == 0) begin
          if (eh) begin
            if (m_lives > 1) begin
              m_lives--; m_mode = 1; m_inv = INV;
            end else begin
              m_lives = 0; m_mode = 2;
            end
          end
        end else begin
          m_inv--;
          if (m_inv == 0) m_mode = 0;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input bit up, input bit down, input bit fire, input bit hit);
    button_up = up; button_down = down; button_fire = fire; projectile_hit = hit;
  endtask

  task automatic checkOutput(input string name);
    logic [N-1:0] exp_oh;
    exp_oh = N'(1) << m_lane;
    total++;
    if (lane_idx !== LW'(m_lane) || lane_onehot !== exp_oh || fire_pulse !== m_pulse ||
        fire_lane !== LW'(m_fire_lane) || lives !== 4'(m_lives) ||
        invulnerable !== (m_mode == 1) || game_over !== (m_mode == 2)) begin
      bad++;
      $display("[TB] FAIL %s t=%0t: got lane=%0d oh=%b pulse=%b fl=%0d lives=%0d inv=%b over=%b; want lane=%0d oh=%b pulse=%b fl=%0d lives=%0d inv=%b over=%b",
               name, $time, lane_idx, lane_onehot, fire_pulse, fire_lane, lives, invulnerable,
               game_over, m_lane, exp_oh, m_pulse, m_fire_lane, m_lives, m_mode == 1, m_mode == 2);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic checkReset(input string name);
    checkValue({name, ".lane_idx"}, int'(lane_idx), START);
    checkValue({name, ".lane_onehot"}, int'(lane_onehot), 1 << START);
    checkValue({name, ".fire_pulse"}, int'(fire_pulse), 0);
    checkValue({name, ".fire_lane"}, int'(fire_lane), START);
    checkValue({name, ".lives"}, int'(lives), NLIVES);
    checkValue({name, ".invulnerable"}, int'(invulnerable), 0);
    checkValue({name, ".game_over"}, int'(game_over), 0);
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_update();
    @(negedge clk);
    checkOutput(name);
    if (fire_pulse) pulse_count++;
  endtask

  typedef struct {
    bit    up, down, fire, hit;
    int    rep, wt;
    int    exp_lane, exp_lives;
    bit    exp_over, exp_inv;
    int    exp_pulses;
    string name;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 1,  4, 1,        3, 0, 0, 0, "up1"};
    vecs[1]  = '{1, 0, 0, 0, 3,  4, 4,        3, 0, 0, 0, "up3"};
    vecs[2]  = '{0, 1, 0, 0, 10, 4, L_DOWN10, 3, 0, 0, 0, "down10"};
    vecs[3]  = '{0, 1, 0, 0, 1,  4, L_DSAT,   3, 0, 0, 0, "down_edge"};
    vecs[4]  = '{1, 1, 0, 0, 1,  4, L_DSAT,   3, 0, 0, 0, "up_and_down"};
    vecs[5]  = '{0, 0, 1, 0, 2,  6, L_DSAT,   3, 0, 0, 2, "fire_twice"};
    vecs[6]  = '{0, 0, 0, 1, 1,  2, L_DSAT,   2, 0, 1, 0, "hit1"};
    vecs[7]  = '{0, 0, 0, 1, 1,  2, L_DSAT,   2, 0, 1, 0, "hit_in_window"};
    vecs[8]  = '{0, 0, 0, 0, 1,  8, L_DSAT,   2, 0, 0, 0, "window_end"};
    vecs[9]  = '{0, 0, 0, 1, 1, 10, L_DSAT,   1, 0, 0, 0, "hit2"};
    vecs[10] = '{0, 0, 0, 1, 1,  2, L_DSAT,   0, 1, 0, 0, "hit3_over"};
    vecs[11] = '{1, 0, 0, 0, 2,  4, L_DSAT,   0, 1, 0, 0, "up_in_over"};
    vecs[12] = '{0, 0, 1, 0, 1,  4, START,    3, 0, 0, 0, "restart"};
    vecs[13] = '{0, 0, 1, 0, 1,  4, START,    3, 0, 0, 1, "fire_after_restart"};

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    model_reset();
    #1;
    checkReset("reset_async");
    repeat (2) tick("reset_hold");
    rst = 1'b0;
    tick("after_reset");

    for (int v = 0; v < 14; v++) begin
      pulse_count = 0;
      for (int r = 0; r < vecs[v].rep; r++) begin
        applyStimulus(vecs[v].up, vecs[v].down, vecs[v].fire, vecs[v].hit);
        tick(vecs[v].name);
        applyStimulus(0, 0, 0, 0);
        for (int w = 0; w < vecs[v].wt; w++) tick(vecs[v].name);
      end
      checkValue({vecs[v].name, ".lane"}, int'(lane_idx), vecs[v].exp_lane);
      checkValue({vecs[v].name, ".lives"}, int'(lives), vecs[v].exp_lives);
      checkValue({vecs[v].name, ".over"}, int'(game_over), int'(vecs[v].exp_over));
      checkValue({vecs[v].name, ".inv"}, int'(invulnerable), int'(vecs[v].exp_inv));
      checkValue({vecs[v].name, ".pulses"}, pulse_count, vecs[v].exp_pulses);
    end

    // Move to lane 2, then fire with an early second press that must be dropped.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1, 0, 0, 0);
      tick("seq_up");
      applyStimulus(0, 0, 0, 0);
      repeat (4) tick("seq_up");
    end
    repeat (4) tick("seq_idle");
    pulse_count = 0;
    applyStimulus(0, 0, 1, 0);
    tick("seq_fire");
    applyStimulus(0, 0, 0, 0);
    for (int k = 0; k < 6 && pulse_count == 0; k++) tick("seq_fire_wait");
    checkValue("seq_first_pulse_seen", pulse_count, 1);
    tick("seq_gap");
    applyStimulus(0, 0, 1, 0);
    tick("seq_early_press");
    applyStimulus(0, 0, 0, 0);
    repeat (8) tick("seq_early_wait");
    checkValue("seq_early_press_dropped", pulse_count, 1);
    pulse_count = 0;
    applyStimulus(0, 0, 1, 0);
    tick("seq_late_press");
    applyStimulus(0, 0, 0, 0);
    for (int k = 0; k < 6 && pulse_count == 0; k++) tick("seq_late_wait");
    checkValue("seq_late_pulse", pulse_count, 1);
    checkValue("seq_late_fire_lane", int'(fire_lane), 2);

    // Hit and fire together, then reset asynchronously while HIT and cooldown run.
    repeat (4) tick("seq_idle2");
    applyStimulus(0, 0, 1, 1);
    tick("seq_hit_fire");
    applyStimulus(0, 0, 0, 0);
    repeat (3) tick("seq_hit_fire_wait");
    checkValue("seq_mid_hit_inv", int'(invulnerable), 1);
    checkValue("seq_mid_hit_lives", int'(lives), 2);
    #2;
    rst = 1'b1;
    #1;
    checkReset("reset_mid_hit");
    model_reset();
    tick("reset_mid_hold");
    rst = 1'b0;
    tick("after_mid_reset");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) button_up = ~button_up;
      if ($urandom_range(3) == 0) button_down = ~button_down;
      if ($urandom_range(3) == 0) button_fire = ~button_fire;
      projectile_hit = ($urandom_range(5) == 0);
      if (rst) rst = 1'b0;
      else rst = ($urandom_range(150) == 0);
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
